// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronises RX, runs the bit FSM off the prescaler halfway pulse,
// and hands bytes out through a one-entry valid/ready register. Define UART_RX_PARITY_EN for a parity bit.
module uart_rx_deframer #(
   parameter int DataBits = 8
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_rx,
   input  logic                i_half,
   input  logic                i_strobe,
   output logic                o_presc_run,
   output logic [DataBits-1:0] o_data,
   output logic                o_valid,
   input  logic                i_ready,
   output logic                o_frame_err,
   output logic                o_parity_err,
   output logic                o_overrun,
   input  logic                i_parity_odd
);

   localparam int CntW = (DataBits > 1) ? $clog2(DataBits) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
`ifdef UART_RX_PARITY_EN
      , ST_PARITY
`endif
   } state_t;

   state_t              state;
   state_t              state_next;
   logic                rx_meta;
   logic                rx_s;
   logic [CntW-1:0]     bit_cnt;
   logic [DataBits-1:0] shift_reg;
   logic                cnt_clr;
   logic                shift_en;
   logic                par_en;
   logic                parity_bad;
   logic                frame_err_d;
   logic                parity_err_d;
   logic                overrun_d;
   logic                load_d;
   logic                unused_inputs;

   // i_strobe is reserved for future stop-bit timing.
   assign unused_inputs = i_strobe ^ i_parity_odd;

`ifdef UART_RX_PARITY_EN
   logic parity_bit;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         parity_bit <= 1'b0;
      end else if (par_en) begin
         parity_bit <= rx_s;
      end
   end

   assign parity_bad = ((^shift_reg) ^ parity_bit) != i_parity_odd;
`else
   assign parity_bad = 1'b0;
`endif

   assign o_presc_run = (state != ST_IDLE);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rx_meta   <= 1'b1;
         rx_s      <= 1'b1;
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         shift_reg <= '0;
      end else begin
         rx_meta <= i_rx;
         rx_s    <= rx_meta;
         state   <= state_next;
         if (cnt_clr) begin
            bit_cnt <= '0;
         end else if (shift_en) begin
            bit_cnt   <= bit_cnt + CntW'(1);
            shift_reg <= {rx_s, shift_reg[DataBits-1:1]};
         end
      end
   end

   always_comb begin
      state_next   = state;
      cnt_clr      = 1'b0;
      shift_en     = 1'b0;
      par_en       = 1'b0;
      frame_err_d  = 1'b0;
      parity_err_d = 1'b0;
      overrun_d    = 1'b0;
      load_d       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!rx_s) state_next = ST_START;
         end
         ST_START: begin
            if (i_half) begin
               if (rx_s) begin
                  state_next = ST_IDLE;
               end else begin
                  state_next = ST_DATA;
                  cnt_clr    = 1'b1;
               end
            end
         end
         ST_DATA: begin
            if (i_half) begin
               shift_en = 1'b1;
               if (bit_cnt == CntW'(DataBits - 1)) begin
`ifdef UART_RX_PARITY_EN
                  state_next = ST_PARITY;
`else
                  state_next = ST_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (i_half) begin
               par_en     = 1'b1;
               state_next = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            // Leaving at mid-stop-bit lets the next start edge be caught without delay.
            if (i_half) begin
               state_next = ST_IDLE;
               if (!rx_s) begin
                  frame_err_d = 1'b1;
               end else if (parity_bad) begin
                  parity_err_d = 1'b1;
               end else if (o_valid && !i_ready) begin
                  overrun_d = 1'b1;
               end else begin
                  load_d = 1'b1;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // A byte landing in the same cycle the old one is taken reloads the register with o_valid kept high.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_data       <= '0;
         o_valid      <= 1'b0;
         o_frame_err  <= 1'b0;
         o_parity_err <= 1'b0;
         o_overrun    <= 1'b0;
      end else begin
         o_frame_err  <= frame_err_d;
         o_parity_err <= parity_err_d;
         o_overrun    <= overrun_d;
         if (load_d) begin
            o_data  <= shift_reg;
            o_valid <= 1'b1;
         end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Scoreboard bench for uart_rx_deframer: a behavioural prescaler and serial transmitter feed
// randomised and directed frames; a negedge monitor checks delivered bytes and error pulses.
module tb_uart_rx_deframer;

   localparam int DataBits  = 8;
   localparam int BitCycles = 16;
`ifdef UART_RX_PARITY_EN
   localparam int ParBits = 1;
`else
   localparam int ParBits = 0;
`endif
   localparam int StopIdx = DataBits + 1 + ParBits;

   localparam int ErrFrame   = 1;
   localparam int ErrParity  = 2;
   localparam int ErrOverrun = 3;

   localparam int ModeNormal  = 0;
   localparam int ModeOverrun = 1;
   localparam int ModeAccept  = 2;
   localparam int ModeNone    = 3;

   logic                i_clk = 1'b0;
   logic                i_rst_n;
   logic                i_rx;
   logic                i_half;
   logic                i_strobe;
   logic                o_presc_run;
   logic [DataBits-1:0] o_data;
   logic                o_valid;
   logic                i_ready;
   logic                o_frame_err;
   logic                o_parity_err;
   logic                o_overrun;
   logic                i_parity_odd;

   int checks   = 0;
   int failures = 0;
   logic [DataBits-1:0] byte_q[$];
   int                  err_q[$];
   bit                  rand_ready = 1'b0;
   int                  presc_cnt;

   uart_rx_deframer #(.DataBits(DataBits)) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_rx         (i_rx),
      .i_half       (i_half),
      .i_strobe     (i_strobe),
      .o_presc_run  (o_presc_run),
      .o_data       (o_data),
      .o_valid      (o_valid),
      .i_ready      (i_ready),
      .o_frame_err  (o_frame_err),
      .o_parity_err (o_parity_err),
      .o_overrun    (o_overrun),
      .i_parity_odd (i_parity_odd)
   );

   always #5 i_clk = ~i_clk;

   // Prescaler model: held at zero while disabled, halfway pulse at count 7 of 16.
   always @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n || !o_presc_run) presc_cnt <= 0;
      else presc_cnt <= (presc_cnt + 1) % BitCycles;
   end
   assign i_half   = o_presc_run && (presc_cnt == 7);
   assign i_strobe = o_presc_run && (presc_cnt == BitCycles - 1);

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic driveBit(input logic b);
      i_rx = b;
      repeat (BitCycles) tick();
   endtask

   // Issue one frame and queue the response the receiver owes for it.
   task automatic applyStimulus(input logic [DataBits-1:0] data, input bit stop_bad,
                                input bit par_bad, input int mode);
      logic par;
      bit   par_wrong;
      par       = (^data) ^ i_parity_odd;
      par_wrong = 1'b0;
      if (par_bad) par = ~par;
`ifdef UART_RX_PARITY_EN
      par_wrong = par_bad;
`endif
      if (stop_bad) err_q.push_back(ErrFrame);
      else if (par_wrong) err_q.push_back(ErrParity);
      else if (mode == ModeOverrun) err_q.push_back(ErrOverrun);
      else if (mode != ModeNone) byte_q.push_back(data);

      driveBit(1'b0);
      for (int i = 0; i < DataBits; i++) driveBit(data[i]);
      if (ParBits == 1) driveBit(par);
      i_rx = ~stop_bad;
      if (mode == ModeAccept) begin
         bit done;
         done = 1'b0;
         for (int c = 0; c < BitCycles; c++) begin
            if (done) i_ready = 1'b0;
            else if (i_half) begin
               i_ready = 1'b1;
               done    = 1'b1;
            end
            tick();
         end
         i_ready = 1'b0;
      end else begin
         repeat (BitCycles) tick();
      end
      i_rx = 1'b1;
      repeat (stop_bad ? 2 * BitCycles : $urandom_range(0, 12)) tick();
   endtask

   task automatic sendBreak(input int frames);
      int first_err;
      first_err = 3 + 8 + BitCycles * StopIdx;
      for (int f = 0; f < frames; f++) err_q.push_back(ErrFrame);
      i_rx = 1'b0;
      repeat (first_err + (frames - 1) * (BitCycles * StopIdx + 9) + 3) tick();
      i_rx = 1'b1;
      repeat (3 * BitCycles) tick();
   endtask

   // Monitor: every transfer and every error pulse is matched against the scoreboard.
   always @(negedge i_clk) begin
      if (i_rst_n) begin
         if (o_valid && i_ready) begin
            if (byte_q.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_byte: got 0x%0h, expected none", o_data);
            end else begin
               checkOutput("rx_byte", int'(o_data), int'(byte_q.pop_front()));
            end
         end else if (o_valid && byte_q.size() != 0) begin
            checkOutput("held_byte", int'(o_data), int'(byte_q[0]));
         end
         if (o_frame_err || o_parity_err || o_overrun) begin
            int kind;
            checkOutput("one_pulse", $countones({o_frame_err, o_parity_err, o_overrun}), 1);
            kind = o_frame_err ? ErrFrame : (o_parity_err ? ErrParity : ErrOverrun);
            if (err_q.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_error: got kind %0d, expected none", kind);
            end else begin
               checkOutput("error_kind", kind, err_q.pop_front());
            end
         end
      end
   end

   always @(posedge i_clk) begin
      #1;
      if (rand_ready) i_ready = 1'($urandom_range(0, 1));
   end

   initial begin
      int wait_cnt;
      i_rst_n      = 1'b0;
      i_rx         = 1'b1;
      i_ready      = 1'b1;
      i_parity_odd = 1'b0;
      repeat (3) tick();
      checkOutput("reset_valid", int'(o_valid), 0);
      checkOutput("reset_data", int'(o_data), 0);
      checkOutput("reset_run", int'(o_presc_run), 0);
      checkOutput("reset_errs", int'({o_frame_err, o_parity_err, o_overrun}), 0);
      i_rst_n = 1'b1;
      repeat (5) tick();
      $display("[TB] directed frames");

      applyStimulus(8'h55, 1'b0, 1'b0, ModeNormal);

      i_rx = 1'b0;
      repeat ($urandom_range(1, 5)) tick();
      i_rx = 1'b1;
      repeat (40) tick();
      checkOutput("glitch_idle_run", int'(o_presc_run), 0);
      checkOutput("glitch_no_valid", int'(o_valid), 0);

      applyStimulus(8'hA3, 1'b1, 1'b0, ModeNormal);
      applyStimulus(8'h3C, 1'b0, 1'b0, ModeNormal);

      i_ready = 1'b0;
      applyStimulus(8'h11, 1'b0, 1'b0, ModeNormal);
      applyStimulus(8'h22, 1'b0, 1'b0, ModeOverrun);
      checkOutput("overrun_held", int'(o_data), 32'h11);
      i_ready = 1'b1;
      repeat (4) tick();

      i_ready = 1'b0;
      applyStimulus(8'h33, 1'b0, 1'b0, ModeNormal);
      applyStimulus(8'h44, 1'b0, 1'b0, ModeAccept);
      checkOutput("swap_valid", int'(o_valid), 1);
      i_ready = 1'b1;
      repeat (4) tick();

`ifdef UART_RX_PARITY_EN
      i_parity_odd = 1'b0;
      applyStimulus(8'h07, 1'b0, 1'b0, ModeNormal);
      applyStimulus(8'h07, 1'b0, 1'b1, ModeNormal);
      i_parity_odd = 1'b1;
      applyStimulus(8'h07, 1'b0, 1'b0, ModeNormal);
      applyStimulus(8'h07, 1'b0, 1'b1, ModeNormal);
      i_parity_odd = 1'b0;
`endif

      sendBreak(2);

      i_ready = 1'b0;
      applyStimulus(8'h5A, 1'b0, 1'b0, ModeNone);
      checkOutput("prereset_valid", int'(o_valid), 1);
      i_rx = 1'b0;
      repeat (3 * BitCycles) tick();
      #3 i_rst_n = 1'b0;
      #1;
      checkOutput("midframe_reset_valid", int'(o_valid), 0);
      checkOutput("midframe_reset_run", int'(o_presc_run), 0);
      i_rx = 1'b1;
      repeat (3) tick();
      i_rst_n = 1'b1;
      i_ready = 1'b1;
      repeat (5) tick();
      applyStimulus(8'hF0, 1'b0, 1'b0, ModeNormal);

      $display("[TB] random frames");
      rand_ready = 1'b1;
      for (int n = 0; n < 30; n++) begin
         i_parity_odd = 1'($urandom_range(0, 1));
         applyStimulus(DataBits'($urandom), ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 7) == 0), ModeNormal);
      end
      rand_ready = 1'b0;
      i_ready    = 1'b1;

      wait_cnt = 0;
      while ((byte_q.size() != 0 || err_q.size() != 0) && wait_cnt < 2000) begin
         tick();
         wait_cnt++;
      end
      checkOutput("bytes_outstanding", byte_q.size(), 0);
      checkOutput("errors_outstanding", err_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
